// File: rtl/vanilla_core_pc_hist_hw_pkg.sv
// rtl/vanilla_core_pc_hist_hw_pkg.sv - shared FSM state and dump record types for the PC histogram
package vanilla_core_pc_hist_hw_pkg;

  localparam int pc_max_lp  = 64;
  localparam int cat_max_lp = 16;
  localparam int cnt_max_lp = 64;

  typedef enum logic [1:0] {
    st_idle,
    st_scan,
    st_ovf,
    st_last
  } state_e;

  // Fields sized for the widest supported instance; the top slices them to its parameters.
  typedef struct packed {
    logic [pc_max_lp-1:0]  pc;
    logic [cat_max_lp-1:0] cat;
    logic [cnt_max_lp-1:0] cnt;
    logic                  ovf;
    logic                  last;
  } rec_s;

  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vanilla_core_pc_hist_hw_cam.sv
// rtl/vanilla_core_pc_hist_hw_cam.sv - parallel PC match with lowest-free allocation
module vanilla_pc_hist_cam
  import vanilla_core_pc_hist_hw_pkg::*;
#(
  parameter  int els_p        = 16,
  parameter  int pc_width_p   = 22,
  localparam int idx_width_lp = safe_clog2(els_p)
) (
  input  logic [els_p-1:0]                 valid,
  input  logic [els_p-1:0][pc_width_p-1:0] pcs,
  input  logic [pc_width_p-1:0]            key,
  output logic                             hit,
  output logic [idx_width_lp-1:0]          hit_idx,
  output logic [idx_width_lp-1:0]          alloc_idx,
  output logic                             full
);

  // Descending walk so the lowest matching / lowest free index wins.
  always_comb begin
    hit       = 1'b0;
    hit_idx   = '0;
    alloc_idx = '0;
    for (int i = els_p - 1; i >= 0; i--) begin
      if (valid[i] && (pcs[i] == key)) begin
        hit     = 1'b1;
        hit_idx = idx_width_lp'(i);
      end
      if (!valid[i]) alloc_idx = idx_width_lp'(i);
    end
  end

  assign full = &valid;

endmodule

// File: rtl/vanilla_core_pc_hist_hw.sv
// rtl/vanilla_core_pc_hist_hw.sv - per-PC event category histogram with valid/ready dump
module vanilla_core_pc_hist_hw
  import vanilla_core_pc_hist_hw_pkg::*;
#(
  parameter  int els_p        = 16,
  parameter  int pc_width_p   = 22,
  parameter  int num_cat_p    = 32,
  parameter  int cnt_width_p  = 32,
  localparam int cat_width_lp = safe_clog2(num_cat_p)
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    en_i,
  input  logic                    ev_v_i,
  input  logic [pc_width_p-1:0]   ev_pc_i,
  input  logic [cat_width_lp-1:0] ev_cat_i,
  input  logic                    dump_v_i,
  input  logic                    dump_clear_i,
  output logic                    out_v_o,
  input  logic                    out_ready_i,
  output logic [pc_width_p-1:0]   out_pc_o,
  output logic [cat_width_lp-1:0] out_cat_o,
  output logic [cnt_width_p-1:0]  out_cnt_o,
  output logic                    out_ovf_o,
  output logic                    out_last_o,
  output logic                    busy_o
);

  localparam int idx_width_lp = safe_clog2(els_p);

  state_e                                             state_q, state_d;
  logic [idx_width_lp-1:0]                            ent_q;
  logic [cat_width_lp-1:0]                            cat_q;
  logic                                               clear_q;
  logic [els_p-1:0]                                   valid_q;
  logic [els_p-1:0][pc_width_p-1:0]                   pc_q;
  logic [els_p-1:0][num_cat_p-1:0][cnt_width_p-1:0]   cnt_q;
  logic [num_cat_p-1:0][cnt_width_p-1:0]              ovf_q;
  logic [cnt_width_p-1:0]                             drop_q, drop_d, snap_q;

  logic                    hit, full, cat_ok, accept, drop_ev, adv, out_v;
  logic                    last_ent, last_cat;
  logic [idx_width_lp-1:0] hit_idx, alloc_idx;
  rec_s                    rec;
  logic                    unused_rec;

  function automatic logic [cnt_width_p-1:0] sat_inc(input logic [cnt_width_p-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  vanilla_pc_hist_cam #(
    .els_p      (els_p),
    .pc_width_p (pc_width_p)
  ) u_cam (
    .valid     (valid_q),
    .pcs       (pc_q),
    .key       (ev_pc_i),
    .hit       (hit),
    .hit_idx   (hit_idx),
    .alloc_idx (alloc_idx),
    .full      (full)
  );

  assign busy_o   = (state_q != st_idle);
  assign cat_ok   = (32'(ev_cat_i) < 32'(num_cat_p));
  assign accept   = en_i && ev_v_i && cat_ok && !busy_o;
  assign drop_ev  = en_i && ev_v_i && (busy_o || !cat_ok);
  assign drop_d   = drop_ev ? sat_inc(drop_q) : drop_q;
  assign last_ent = (ent_q == idx_width_lp'(els_p - 1));
  assign last_cat = (cat_q == cat_width_lp'(num_cat_p - 1));

  always_comb begin
    state_d = state_q;
    rec     = '0;
    out_v   = 1'b0;
    adv     = 1'b0;
    case (state_q)
      st_idle: if (dump_v_i) state_d = st_scan;
      st_scan: begin
        if (valid_q[ent_q] && (cnt_q[ent_q][cat_q] != '0)) begin
          out_v   = 1'b1;
          rec.pc  = pc_max_lp'(pc_q[ent_q]);
          rec.cat = cat_max_lp'(cat_q);
          rec.cnt = cnt_max_lp'(cnt_q[ent_q][cat_q]);
          adv     = out_ready_i;
        end else begin
          adv = 1'b1;
        end
        if (adv && last_ent && last_cat) state_d = st_ovf;
      end
      st_ovf: begin
        if (ovf_q[cat_q] != '0) begin
          out_v   = 1'b1;
          rec.ovf = 1'b1;
          rec.cat = cat_max_lp'(cat_q);
          rec.cnt = cnt_max_lp'(ovf_q[cat_q]);
          adv     = out_ready_i;
        end else begin
          adv = 1'b1;
        end
        if (adv && last_cat) state_d = st_last;
      end
      st_last: begin
        out_v    = 1'b1;
        rec.last = 1'b1;
        rec.cnt  = cnt_max_lp'(snap_q);
        if (out_ready_i) state_d = st_idle;
      end
      default: state_d = st_idle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= st_idle;
      ent_q   <= '0;
      cat_q   <= '0;
      clear_q <= 1'b0;
      valid_q <= '0;
      pc_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= '0;
      drop_q  <= '0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      if (state_q == st_idle && dump_v_i) begin
        clear_q <= dump_clear_i;
        ent_q   <= '0;
        cat_q   <= '0;
      end
      if (adv) begin
        cat_q <= last_cat ? '0 : cat_q + 1'b1;
        if (state_q == st_scan && last_cat) ent_q <= last_ent ? '0 : ent_q + 1'b1;
      end
      // LAST reports the dropped count frozen on entry so its payload cannot move while stalled.
      if (state_q == st_ovf && state_d == st_last) snap_q <= drop_d;
      if (accept) begin
        if (hit) begin
          cnt_q[hit_idx][ev_cat_i] <= sat_inc(cnt_q[hit_idx][ev_cat_i]);
        end else if (!full) begin
          valid_q[alloc_idx]          <= 1'b1;
          pc_q[alloc_idx]             <= ev_pc_i;
          cnt_q[alloc_idx][ev_cat_i]  <= cnt_width_p'(1);
        end else begin
          ovf_q[ev_cat_i] <= sat_inc(ovf_q[ev_cat_i]);
        end
      end
      if (state_q == st_last && out_ready_i && clear_q) begin
        valid_q <= '0;
        cnt_q   <= '0;
        ovf_q   <= '0;
        drop_q  <= '0;
      end
    end
  end

  assign out_v_o    = out_v;
  assign out_pc_o   = rec.pc[pc_width_p-1:0];
  assign out_cat_o  = rec.cat[cat_width_lp-1:0];
  assign out_cnt_o  = rec.cnt[cnt_width_p-1:0];
  assign out_ovf_o  = rec.ovf;
  assign out_last_o = rec.last;
  assign unused_rec = ^rec;

endmodule

// File: doc/vanilla_core_pc_hist_hw.md
VANILLA_CORE_PC_HIST_HW -- requirements
Module: vanilla_core_pc_hist_hw

Interface
REQ-001 SHALL have parameter els_p, default 16, number of tracked PC entries.
REQ-002 SHALL have parameter pc_width_p, default 22, PC width.
REQ-003 SHALL have parameter num_cat_p, default 32, event categories per entry.
REQ-004 SHALL have parameter cnt_width_p, default 32, counter width; cat_width_lp = safe clog2(num_cat_p) is derived, not overridable.
REQ-005 SHALL have port clk_i  in  1  sole clock; all state changes on its rising edge.
REQ-006 SHALL have port reset_n_i  in  1  reset, synchronous and active-low.
REQ-007 SHALL have port en_i  in  1  counting enable; event ignored (not dropped) when low.
REQ-008 SHALL have port ev_v_i  in  1  one event this cycle.
REQ-009 SHALL have port ev_pc_i  in  pc_width_p  event PC.
REQ-010 SHALL have port ev_cat_i  in  cat_width_lp  event category.
REQ-011 SHALL have port dump_v_i  in  1  start dump; sampled only in IDLE.
REQ-012 SHALL have port dump_clear_i  in  1  clear-after-dump mode, sampled with dump_v_i.
REQ-013 SHALL have port out_v_o / out_ready_i  out/in  1/1  dump record valid-ready handshake.
REQ-014 SHALL have ports out_pc_o, out_cat_o, out_cnt_o  out  pc_width_p, cat_width_lp, cnt_width_p  record payload.
REQ-015 SHALL have ports out_ovf_o, out_last_o  out  1, 1  overflow-row flag, terminal-record flag.
REQ-016 SHALL have port busy_o  out  1  high in every state except IDLE.

Function
REQ-017 SHALL keep els_p entries (valid, pc) each with num_cat_p saturating counters, plus num_cat_p overflow counters and one dropped counter.
REQ-018 In IDLE, an accepted event (en_i & ev_v_i & ev_cat_i < num_cat_p) SHALL increment the matching entry's counter, visible one cycle later.
REQ-019 On PC miss, SHALL allocate the lowest-index invalid entry, set pc, and count into it in the same cycle.
REQ-020 On miss with all entries valid, SHALL increment overflow counter[ev_cat_i].
REQ-021 Counters SHALL saturate at all-ones; no wrap.
REQ-022 ev_cat_i >= num_cat_p with en_i & ev_v_i SHALL increment the dropped counter (saturating), no other effect.
REQ-023 Any event with en_i & ev_v_i while busy_o SHALL increment the dropped counter only.
REQ-024 FSM states: IDLE, SCAN, OVF, LAST; IDLE->SCAN on dump_v_i; SCAN->OVF after entry els_p-1, category num_cat_p-1; OVF->LAST after category num_cat_p-1; LAST->IDLE on out_ready_i.
REQ-025 SCAN SHALL visit (entry, category) in entry-major order, one position per cycle, skipping invalid entries and zero counters without asserting out_v_o.
REQ-026 A nonzero position SHALL assert out_v_o with payload held stable until out_ready_i; the pointer advances the cycle after the handshake.
REQ-027 OVF SHALL emit nonzero overflow counters with out_ovf_o=1, out_pc_o=0.
REQ-028 LAST SHALL emit one record: out_last_o=1, out_pc_o=0, out_cat_o=0, out_cnt_o=dropped count.
REQ-029 With dump_clear latched, on the LAST handshake SHALL invalidate all entries and zero all counters including dropped; else state is unchanged.
REQ-030 out_v_o SHALL never depend combinationally on out_ready_i.

Reset
REQ-031 reset_n_i low SHALL force IDLE, invalidate all entries, zero all counters; outputs out_v_o, out_ovf_o, out_last_o, busy_o = 0, payload = 0.
REQ-032 Reset mid-dump SHALL abort immediately; no further records emitted.

Structure
REQ-033 Shared package SHALL hold the FSM state enum and the dump record struct (pc, cat, cnt, ovf, last).
REQ-034 SHALL use one sub-module vanilla_pc_hist_cam: parallel PC match, hit index, lowest-free allocate index, full flag.

Verification
REQ-035 Reset, events pc=0x100 cat=3 x5, dump -> record (0x100,3,5), then LAST cnt=0.
REQ-036 els_p+1 distinct PCs, cat=1 each -> els_p entry records cnt=1, one OVF record cat=1 cnt=1.
REQ-037 cnt_width_p=4, 20 events same pc/cat -> record cnt=15.
REQ-038 Dump with out_ready_i low 3 cycles per record, 2 events during dump -> payload stable, LAST cnt=2.
REQ-039 dump_clear_i=1, dump, then dump again -> second dump emits only LAST cnt=0.
REQ-040 Assert reset_n_i low mid-SCAN -> next cycle busy_o=0, out_v_o=0, subsequent dump emits only LAST.
